// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode,
// execute, memory and write-back, and stretches memory states on mem_ready.
module multi_cycle_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH        = 4'd0,
        DECODE       = 4'd1,
        MEM_ADDR     = 4'd2,
        MEM_READ     = 4'd3,
        MEM_WB       = 4'd4,
        MEM_WRITE    = 4'd5,
        EXECUTE      = 4'd6,
        R_COMPLETE   = 4'd7,
        BRANCH       = 4'd8,
        JUMP         = 4'd9,
        IMM_EXEC     = 4'd10,
        IMM_COMPLETE = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_branch_ne;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_ext_zero;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_instr_done;
    logic       w_illegal;

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state control decode; everything defaults to 0.
    always_comb begin
        w_next_state    = FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_branch_ne     = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_ext_zero      = 1'b0;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_instr_done    = 1'b0;
        w_illegal       = 1'b0;
        case (r_state)
            FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
                if (mem_ready) begin
                    w_next_state = DECODE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:     w_next_state = MEM_ADDR;
                    OP_R:             w_next_state = EXECUTE;
                    OP_BEQ, OP_BNE:   w_next_state = BRANCH;
                    OP_J:             w_next_state = JUMP;
                    OP_ADDI, OP_ANDI: w_next_state = IMM_EXEC;
                    default: begin
                        w_next_state = FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                case (opcode)
                    OP_LW:   w_next_state = MEM_READ;
                    OP_SW:   w_next_state = MEM_WRITE;
                    default: w_next_state = FETCH;
                endcase
            end
            MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (mem_ready) begin
                    w_next_state = MEM_WB;
                end else begin
                    w_next_state = MEM_READ;
                end
            end
            MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = FETCH;
            end
            MEM_WRITE: begin
                w_mem_write  = 1'b1;
                w_i_or_d     = 1'b1;
                w_instr_done = mem_ready;
                if (mem_ready) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = MEM_WRITE;
                end
            end
            EXECUTE: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b10;
                w_next_state = R_COMPLETE;
            end
            R_COMPLETE: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = FETCH;
            end
            BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_instr_done    = 1'b1;
                w_branch_ne     = (opcode == OP_BNE);
                w_next_state    = FETCH;
            end
            JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = 2'b10;
                w_instr_done = 1'b1;
                w_next_state = FETCH;
            end
            IMM_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                // andi needs a logical AND on a zero-extended immediate
                if (opcode == OP_ANDI) begin
                    w_alu_op   = 2'b11;
                    w_ext_zero = 1'b1;
                end else begin
                    w_alu_op   = 2'b00;
                    w_ext_zero = 1'b0;
                end
                w_next_state = IMM_COMPLETE;
            end
            IMM_COMPLETE: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = FETCH;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // Gate with reset_n so FETCH's mem_read stays quiet while reset is held.
    assign pc_write      = reset_n & w_pc_write;
    assign pc_write_cond = reset_n & w_pc_write_cond;
    assign branch_ne     = reset_n & w_branch_ne;
    assign i_or_d        = reset_n & w_i_or_d;
    assign mem_read      = reset_n & w_mem_read;
    assign mem_write     = reset_n & w_mem_write;
    assign ir_write      = reset_n & w_ir_write;
    assign mem_to_reg    = reset_n & w_mem_to_reg;
    assign reg_write     = reset_n & w_reg_write;
    assign reg_dst       = reset_n & w_reg_dst;
    assign alu_src_a     = reset_n & w_alu_src_a;
    assign alu_src_b     = {2{reset_n}} & w_alu_src_b;
    assign ext_zero      = reset_n & w_ext_zero;
    assign alu_op        = {2{reset_n}} & w_alu_op;
    assign pc_source     = {2{reset_n}} & w_pc_source;
    assign instr_done    = reset_n & w_instr_done;
    assign illegal       = reset_n & w_illegal;
    assign state         = r_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-instruction state walks with
// hand-computed state sequences and control values.
module tb_multi_cycle_control;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, ext_zero;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal;
    logic [3:0] state;
    logic [23:0] all_out;

    int checks = 0;
    int failures = 0;

    multi_cycle_control dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_zero(ext_zero), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clock = ~clock;

    assign all_out = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b,
                      ext_zero, alu_op, pc_source, instr_done, illegal, state};

    task automatic test_reset;
        reset_n = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            opcode = 6'd9 * i[5:0];
            #1;
            checks++;
            if (all_out !== 24'd0) begin
                failures++;
                $display("FAIL reset_outputs: got %h expected %h", all_out, 24'd0);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: state=%0d mem_read=%b expected state=0 mem_read=1", state, mem_read);
        end
    endtask

    task automatic test_rtype;
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'b000000;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if (state !== seq[i]) begin
                failures++;
                $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, seq[i]);
            end
            checks++;
            if (instr_done !== (i == 3)) begin
                failures++;
                $display("FAIL rtype_done[%0d]: got %b expected %b", i, instr_done, (i == 3));
            end
            if (i == 2) begin
                checks++;
                if (alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
                    failures++;
                    $display("FAIL rtype_exec: alu_op=%b src_a=%b src_b=%b expected 10 1 00", alu_op, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                checks++;
                if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
                    failures++;
                    $display("FAIL rtype_wb: reg_write=%b reg_dst=%b mem_to_reg=%b expected 1 1 0", reg_write, reg_dst, mem_to_reg);
                end
            end
        end
    endtask

    task automatic test_lw_stall;
        logic [3:0] seq [8];
        logic       mr [8];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== seq[i]) begin
                failures++;
                $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, seq[i]);
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (mem_read !== 1'b1 || i_or_d !== 1'b1 || instr_done !== 1'b0 || ir_write !== 1'b0) begin
                    failures++;
                    $display("FAIL lw_memread[%0d]: mem_read=%b i_or_d=%b done=%b ir_write=%b expected 1 1 0 0", i, mem_read, i_or_d, instr_done, ir_write);
                end
            end
            if (i == 6) begin
                checks++;
                if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0 || instr_done !== 1'b1) begin
                    failures++;
                    $display("FAIL lw_wb: reg_write=%b mem_to_reg=%b reg_dst=%b done=%b expected 1 1 0 1", reg_write, mem_to_reg, reg_dst, instr_done);
                end
            end
        end
    endtask

    task automatic test_branch;
        logic [5:0] ops [2];
        ops = '{6'b000100, 6'b000101};
        mem_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            opcode = ops[b];
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clock);
                #1;
                checks++;
                if (state !== ((i == 1) ? 4'd1 : (i == 2) ? 4'd8 : 4'd0)) begin
                    failures++;
                    $display("FAIL branch%0d_state[%0d]: got %0d", b, i, state);
                end
                if (i == 2) begin
                    checks++;
                    if ({alu_op, pc_write_cond, pc_source, branch_ne, instr_done, pc_write} !== {2'b01, 1'b1, 2'b01, (b == 1), 1'b1, 1'b0}) begin
                        failures++;
                        $display("FAIL branch%0d_ctrl: alu_op=%b pwc=%b pc_src=%b bne=%b done=%b pcw=%b", b, alu_op, pc_write_cond, pc_source, branch_ne, instr_done, pc_write);
                    end
                end
            end
        end
    endtask

    task automatic test_jump;
        opcode = 6'b000010;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if (state !== ((i == 1) ? 4'd1 : (i == 2) ? 4'd9 : 4'd0)) begin
                failures++;
                $display("FAIL jump_state[%0d]: got %0d", i, state);
            end
            if (i == 2) begin
                checks++;
                if (pc_write !== 1'b1 || pc_source !== 2'b10 || instr_done !== 1'b1) begin
                    failures++;
                    $display("FAIL jump_ctrl: pcw=%b pc_src=%b done=%b expected 1 10 1", pc_write, pc_source, instr_done);
                end
            end
        end
    endtask

    task automatic test_imm;
        logic [5:0] ops [2];
        ops = '{6'b001100, 6'b001000};
        mem_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            opcode = ops[b];
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clock);
                #1;
                checks++;
                if (state !== ((i == 1) ? 4'd1 : (i == 2) ? 4'd10 : (i == 3) ? 4'd11 : 4'd0)) begin
                    failures++;
                    $display("FAIL imm%0d_state[%0d]: got %0d", b, i, state);
                end
                if (i == 2) begin
                    checks++;
                    if ({alu_op, ext_zero, alu_src_a, alu_src_b} !== {((b == 0) ? 2'b11 : 2'b00), (b == 0), 1'b1, 2'b10}) begin
                        failures++;
                        $display("FAIL imm%0d_exec: alu_op=%b ext_zero=%b src_a=%b src_b=%b", b, alu_op, ext_zero, alu_src_a, alu_src_b);
                    end
                end
                if (i == 3) begin
                    checks++;
                    if (reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0 || instr_done !== 1'b1) begin
                        failures++;
                        $display("FAIL imm%0d_wb: reg_write=%b reg_dst=%b mem_to_reg=%b done=%b expected 1 0 0 1", b, reg_write, reg_dst, mem_to_reg, instr_done);
                    end
                end
            end
        end
    endtask

    task automatic test_illegal;
        opcode = 6'b111111;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if ({state, illegal, instr_done} !== {((i == 1) ? 4'd1 : 4'd0), (i == 1), 1'b0}) begin
                failures++;
                $display("FAIL illegal[%0d]: state=%0d illegal=%b done=%b", i, state, illegal, instr_done);
            end
        end
    endtask

    task automatic test_sw_fetch_stall;
        logic [3:0] seq [6];
        logic       mr [6];
        seq = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        mr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== seq[i]) begin
                failures++;
                $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, seq[i]);
            end
            if (i == 0) begin
                checks++;
                if (mem_read !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_wait: mem_read=%b ir_write=%b pcw=%b expected 1 0 0", mem_read, ir_write, pc_write);
                end
            end
            if (i == 1) begin
                checks++;
                if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
                    failures++;
                    $display("FAIL fetch_go: ir_write=%b pcw=%b expected 1 1", ir_write, pc_write);
                end
            end
            if (i == 4) begin
                checks++;
                if (mem_write !== 1'b1 || i_or_d !== 1'b1 || instr_done !== 1'b1) begin
                    failures++;
                    $display("FAIL sw_write: mem_write=%b i_or_d=%b done=%b expected 1 1 1", mem_write, i_or_d, instr_done);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sw;
        logic [3:0] seq [4];
        logic       mr [4];
        seq = '{4'd0, 4'd1, 4'd2, 4'd5};
        mr  = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== seq[i]) begin
                failures++;
                $display("FAIL swrst_state[%0d]: got %0d expected %0d", i, state, seq[i]);
            end
        end
        checks++;
        if (mem_write !== 1'b1 || instr_done !== 1'b0) begin
            failures++;
            $display("FAIL sw_hold: mem_write=%b done=%b expected 1 0", mem_write, instr_done);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || state !== 4'd0 || all_out !== 24'd0) begin
            failures++;
            $display("FAIL sw_async_reset: mem_write=%b state=%0d outs=%h expected 0 0 0", mem_write, state, all_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL sw_reset_release: state=%0d mem_read=%b expected 0 1", state, mem_read);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_jump();
        test_imm();
        test_illegal();
        test_sw_fetch_stall();
        test_reset_mid_sw();
        test_rtype();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control FSM for the multi-cycle MIPS datapath; directly upstream of the ALU control decoder, which consumes its `alu_op` output together with the instruction `funct` field. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives all datapath mux selects and write enables. A `mem_ready` handshake stretches memory-access states.

## Interface
Parameters: none; opcode values are fixed MIPS encodings.

Ports:
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]. Stable from DECODE until the instruction retires.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: unconditional PC write.
- `pc_write_cond` output 1: conditional PC write on the branch outcome.
- `branch_ne` output 1: inverts the zero condition for `bne`.
- `i_or_d` output 1: memory address select; 0=PC, 1=ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: IR load.
- `mem_to_reg` output 1: write-back data select; 1=MDR, 0=ALUOut.
- `reg_write` output 1: register file write.
- `reg_dst` output 1: destination register select; 1=rd, 0=rt.
- `alu_src_a` output 1: ALU A select; 0=PC, 1=A.
- `alu_src_b` output 2: ALU B select; 00=B, 01=4, 10=sext imm, 11=sext imm<<2.
- `ext_zero` output 1: zero-extend the immediate instead of sign-extending.
- `alu_op` output 2: to the ALU control decoder; 00=add, 01=sub, 10=R-type funct, 11=and.
- `pc_source` output 2: PC source select; 00=ALU result, 01=ALUOut, 10=jump target.
- `instr_done` output 1: one-cycle retire pulse.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.
- `state` output 4: current state, for debug.

## Operation
- The state register is the only storage. Outputs are combinational from `state`, plus the noted `mem_ready`/`opcode` terms. Any output not listed for a state is 0.
- Supported opcodes:
  - R=000000
  - lw=100011
  - sw=101011
  - beq=000100
  - bne=000101
  - addi=001000
  - andi=001100
  - j=000010
- State encodings and behaviour:
  - FETCH (0):
    - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - ir_write=pc_write=mem_ready.
    - Next state: DECODE if mem_ready, else FETCH.
  - DECODE (1):
    - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
    - lw/sw → MEM_ADDR.
    - R → EXECUTE.
    - beq/bne → BRANCH.
    - j → JUMP.
    - addi/andi → IMM_EXEC.
    - Other opcodes → FETCH with illegal=1 and no instr_done.
  - MEM_ADDR (2):
    - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
    - lw → MEM_READ; sw → MEM_WRITE.
  - MEM_READ (3):
    - Outputs: mem_read=1, i_or_d=1.
    - Next state: MEM_WB if mem_ready, else hold.
  - MEM_WB (4):
    - Outputs: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1.
    - Next state: FETCH.
  - MEM_WRITE (5):
    - Outputs: mem_write=1, i_or_d=1, instr_done=mem_ready.
    - Next state: FETCH if mem_ready, else hold.
  - EXECUTE (6):
    - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
    - Next state: R_COMPLETE.
  - R_COMPLETE (7):
    - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
    - Next state: FETCH.
  - BRANCH (8):
    - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
    - branch_ne=(opcode==bne).
    - Next state: FETCH.
  - JUMP (9):
    - Outputs: pc_write=1, pc_source=10, instr_done=1.
    - Next state: FETCH.
  - IMM_EXEC (10):
    - Outputs: alu_src_a=1, alu_src_b=10.
    - alu_op=11 and ext_zero=1 for andi; alu_op=00 and ext_zero=0 for addi.
    - Next state: IMM_COMPLETE.
  - IMM_COMPLETE (11):
    - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
    - Next state: FETCH.
- State codes 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.

## Timing
- Reset:
  - reset_n=0 forces state=FETCH immediately, without waiting for a clock edge.
  - While reset_n=0, every output is 0, including mem_read and state (FETCH=0).
  - The first fetch begins on the first clock edge after reset_n rises.
  - Reset asserted mid-instruction abandons that instruction with no write enable asserted.
- Latency with mem_ready held at 1, in clock cycles including FETCH:
  - j, beq, bne: 3.
  - R-type, sw, addi, andi: 4.
  - lw: 5.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- While waiting in those states:
  - ir_write, pc_write and instr_done stay 0.
  - mem_read or mem_write stays asserted continuously.
- instr_done is high for exactly one cycle per retired instruction.
- illegal is high for exactly one cycle, in DECODE.
- opcode is sampled combinationally in DECODE, MEM_ADDR, BRANCH and IMM_EXEC. It must not change while the instruction is in flight.

## Test plan
- Reset: hold reset_n=0 across clock edges, then raise it. Required: all outputs 0 while low; state=0 and mem_read=1 on the first cycle after release.
- R-type, opcode=000000, mem_ready=1. Required: state sequence 0,1,6,7,0; alu_op=10 in state 6; reg_write=1 and reg_dst=1 in state 7; instr_done in state 7 only.
- lw with mem_ready low for 2 cycles in MEM_READ. Required: sequence 0,1,2,3,3,3,4,0; mem_read and i_or_d=1 throughout state 3; reg_write and mem_to_reg=1 in state 4.
- beq then bne. Required: sequence 0,1,8 for each; in state 8, alu_op=01, pc_write_cond=1 and pc_source=01; branch_ne=0 for beq and 1 for bne.
- andi then addi. Required: state 10 shows alu_op=11 with ext_zero=1 for andi, and alu_op=00 with ext_zero=0 for addi; state 11 asserts reg_write with reg_dst=0.
- Illegal opcode 111111: illegal=1 for one cycle in DECODE, return to FETCH, no instr_done. Separately, assert reset_n=0 mid-sw during MEM_WRITE: mem_write drops immediately, state=0.
